// File: rtl/pair_bus_fifo.sv
// Valid/ready FIFO of {a, b, sgn} pairs; the head entry is presented with its extended sum.
// Optional macro PAIR_FIFO_PARITY_EN stores a per-entry parity bit and drives out_par from it.
module pair_bus_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:W]               in_a,
  input  logic [1:W]               in_b,
  input  logic                     in_sgn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:W]               out_a,
  output logic [1:W]               out_b,
  output logic [1:W+1]             out_sum,
  output logic                     out_par,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:8]               drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop;

  logic [1:W] mem_a_q   [DEPTH];
  logic [1:W] mem_b_q   [DEPTH];
  logic       mem_sgn_q [DEPTH];

  logic [1:W] head_a, head_b;
  logic       head_sgn;
  logic [W:0] ext_a, ext_b;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: every signal assigned here gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A full FIFO does not let a same-cycle pop free a slot, so in_ready alone decides a drop.
    if (in_valid && !in_ready && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]   <= in_a;
      mem_b_q[wr_ptr_q]   <= in_b;
      mem_sgn_q[wr_ptr_q] <= in_sgn;
    end
  end

  assign head_a   = mem_a_q[rd_ptr_q];
  assign head_b   = mem_b_q[rd_ptr_q];
  assign head_sgn = mem_sgn_q[rd_ptr_q];

  // One extra bit (sign or zero) makes the sum exact for both interpretations.
  assign ext_a = {head_sgn & head_a[1], head_a};
  assign ext_b = {head_sgn & head_b[1], head_b};

  assign out_a    = out_valid ? head_a : '0;
  assign out_b    = out_valid ? head_b : '0;
  assign out_sum  = out_valid ? (ext_a + ext_b) : '0;
  assign count    = count_q;
  assign drop_cnt = drop_q;

`ifdef PAIR_FIFO_PARITY_EN
  logic mem_par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_par_q[wr_ptr_q] <= ^{in_a, in_b};
  end

  assign out_par = out_valid & mem_par_q[rd_ptr_q];
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_pair_bus_fifo.sv
// Randomized scoreboard bench for pair_bus_fifo: a queue-based reference model tracks
// accepted pairs and drops; a negedge monitor compares DUT outputs against it.
module tb_pair_bus_fifo;

  localparam int W     = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [1:W] a;
    logic [1:W] b;
    logic [W:0] sum;
    logic       par;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sgn;
  logic [1:W]    in_a, in_b;
  logic          out_valid, out_ready, out_par;
  logic [1:W]    out_a, out_b;
  logic [1:W+1]  out_sum;
  logic [CW-1:0] count;
  logic [1:8]    drop_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   model_cnt  = 0;
  int   model_drop = 0;

  pair_bus_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sgn(in_sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_sum(out_sum), .out_par(out_par),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [1:W] a, input logic [1:W] b, input logic sgn);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (sgn) begin
      if (ia >= 2 ** (W - 1)) ia -= 2 ** W;
      if (ib >= 2 ** (W - 1)) ib -= 2 ** W;
    end
    return (W + 1)'(ia + ib);
  endfunction

  function automatic logic ref_par(input logic [1:W] a, input logic [1:W] b);
`ifdef PAIR_FIFO_PARITY_EN
    int ones = 0;
    for (int i = 1; i <= W; i++) ones += int'(a[i]) + int'(b[i]);
    return logic'(ones % 2);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: decides acceptance from its own occupancy and records expected responses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      model_cnt  = 0;
      model_drop = 0;
    end else begin
      int  pre;
      bit  acc, take;
      exp_t e;
      pre  = model_cnt;
      acc  = in_valid && (pre < DEPTH);
      take = out_ready && (pre > 0);
      if (acc) begin
        e.a   = in_a;
        e.b   = in_b;
        e.sum = ref_sum(in_a, in_b, in_sgn);
        e.par = ref_par(in_a, in_b);
        exp_q.push_back(e);
      end else if (in_valid && model_drop < 255) begin
        model_drop++;
      end
      model_cnt = pre + int'(acc) - int'(take);
    end
  end

  // Monitor: compares flags and head entry mid-cycle, retiring the head when it is consumed.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, model_cnt < DEPTH);
      check("out_valid", out_valid, model_cnt > 0);
      check("count", count, model_cnt);
      check("drop_cnt", drop_cnt, model_drop);
      if (exp_q.size() > 0) begin
        check("out_a", out_a, exp_q[0].a);
        check("out_b", out_b, exp_q[0].b);
        check("out_sum", out_sum, exp_q[0].sum);
        check("out_par", out_par, exp_q[0].par);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r);
    in_valid  = v;
    out_ready = r;
    in_a      = W'($urandom);
    in_b      = W'($urandom);
    in_sgn    = 1'($urandom);
    tick();
  endtask

  task automatic sync_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
  endtask

  logic exp_par;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sgn = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_par", out_par, 0);
    tick(); tick();
    rst = 1'b0;

    // Fill and drain a single pair.
    in_valid = 1'b1; in_a = 5'd3; in_b = 5'd4; in_sgn = 1'b0;
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_sum", out_sum, 6'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_drained", count, 0);

    // Same operands, signed then unsigned.
    in_valid = 1'b1; in_a = 5'b11111; in_b = 5'b00001; in_sgn = 1'b1;
    tick();
    in_sgn = 1'b0;
    tick();
    in_valid = 1'b0;
    check("signed_sum", out_sum, 6'b000000);
    out_ready = 1'b1;
    tick();
    check("unsigned_sum", out_sum, 6'b100000);
    tick();
    out_ready = 1'b0;

    // Full and drop, then FIFO-order drain.
    sync_reset();
    repeat (7) drive(1'b1, 1'b0);
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 4);
    check("full_drop", drop_cnt, 3);
    repeat (4) drive(1'b0, 1'b1);

    // Drop counter saturation.
    repeat (4 + 300) drive(1'b1, 1'b0);
    in_valid = 1'b0;
    check("drop_saturated", drop_cnt, 255);
    repeat (4) drive(1'b0, 1'b1);

    // Concurrent push and pop at occupancy 2.
    repeat (2) drive(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1);
      check("concurrent_count", count, 2);
    end
    repeat (2) drive(1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    repeat (DEPTH + 1) drive(1'b0, 1'b1);

    // Asynchronous reset pulse mid-cycle with three entries held.
    repeat (3) drive(1'b1, 1'b0);
    in_valid = 1'b0;
    check("pre_reset_count", count, 3);
    #2 rst = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Parity of a single set bit.
    in_valid = 1'b1; in_a = 5'b10000; in_b = 5'b00000; in_sgn = 1'b0;
    tick();
    in_valid = 1'b0;
`ifdef PAIR_FIFO_PARITY_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    check("parity_head", out_par, exp_par);
    repeat (2) drive(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
